// File: rtl/ahb_imem_slave.sv
// AHB-Lite read-only slave serving instruction memory to the cache refill master.
// Drives a synchronous single-port macro, with optional wait states and two-cycle ERROR replies.
module ahb_imem_slave #(
  parameter int unsigned MEM_BYTES   = 32'd16384,
  parameter int unsigned WAIT_CYCLES = 32'd0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int unsigned AW         = $clog2(MEM_BYTES) - 32'd2
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic          HREADY,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          mem_cen,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_MAX = WAIT_CYCLES[2:0];

  state_t        state_r;
  state_t        state_nxt_s;
  logic [2:0]    wait_cnt_r;
  logic [31:0]   hold_r;
  logic [31:0]   data_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   offset_s;
  logic          accept_s;
  logic          out_of_range_s;
  logic          is_err_s;
  logic          rd_issue_s;
  logic          rd_done_s;
  logic [31:0]   rd_word_s;
  logic          unused_s;

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = lsb[0];
      3'd2:    bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign unused_s       = ^{HBURST, HTRANS[0]};
  assign offset_s       = HADDR - BASE_ADDR;
  assign accept_s       = HSEL & HREADY & HTRANS[1];
  assign out_of_range_s = (offset_s >= MEM_BYTES);
  assign is_err_s       = HWRITE | out_of_range_s | misaligned(HSIZE, HADDR[1:0]);
  // Only issue a memory read when this slave is ready to take the address phase.
  assign rd_issue_s     = accept_s & ~is_err_s & HREADYOUT;

  assign mem_cen   = ~rd_issue_s;
  assign mem_addr  = rd_issue_s ? offset_s[AW+1:2] : addr_r;
  assign rd_done_s = (state_r == ST_RD) & HREADYOUT;
  assign rd_word_s = (WAIT_MAX == 3'd0) ? mem_dout : hold_r;
  assign HRDATA    = rd_done_s ? rd_word_s : data_r;

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: every ready cycle hands over to whatever the bus presents.
  always_comb begin
    state_t bus_nxt;
    if (!accept_s) begin
      bus_nxt = ST_IDLE;
    end else if (is_err_s) begin
      bus_nxt = ST_ERR1;
    end else begin
      bus_nxt = ST_RD;
    end
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = bus_nxt;
      ST_RD: begin
        if (HREADYOUT) begin
          state_nxt_s = bus_nxt;
        end else begin
          state_nxt_s = ST_RD;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      ST_ERR2: state_nxt_s = bus_nxt;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode of the data-phase handshake.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
      ST_RD: begin
        HREADYOUT = (wait_cnt_r == WAIT_MAX);
        HRESP     = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // Wait-state counter: saturates at WAIT_MAX, clears when the read completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_r <= 3'd0;
    end else if (state_r != ST_RD) begin
      wait_cnt_r <= 3'd0;
    end else if (rd_done_s) begin
      wait_cnt_r <= 3'd0;
    end else if (wait_cnt_r != WAIT_MAX) begin
      wait_cnt_r <= wait_cnt_r + 3'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Macro output is only valid in the first data cycle, so hold it for the stall.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_r <= 32'd0;
    end else if ((state_r == ST_RD) && (wait_cnt_r == 3'd0)) begin
      hold_r <= mem_dout;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Last completed read word, presented whenever no read is completing.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_r <= 32'd0;
    end else if (rd_done_s) begin
      data_r <= rd_word_s;
    end else begin
      data_r <= data_r;
    end
  end

  // Last issued word address, so mem_addr stays put between accesses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r <= '0;
    end else if (rd_issue_s) begin
      addr_r <= offset_s[AW+1:2];
    end else begin
      addr_r <= addr_r;
    end
  end

endmodule

// File: tb/tb_ahb_imem_slave.sv
// Bench for ahb_imem_slave: three instances (0, 2 and 3 wait states) share one bus,
// each checked cycle by cycle against a transaction-level response model.
module tb_ahb_imem_slave;

  localparam int MB  = 1024;
  localparam int AW  = 8;
  localparam int WAITS [3] = '{0, 2, 3};

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic        sel;
  } item_t;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } ph_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic          hready;
  logic [31:0]   hrdata [3];
  logic [2:0]    hro;
  logic [2:0]    hrs;
  logic [2:0]    cen;
  logic [AW-1:0] maddr [3];
  logic [31:0]   mem [MB/4];
  logic [31:0]   ldata [3];
  int            cur;
  int            errs = 0;
  int            checks = 0;
  item_t         q[$];

  always #5 clk = ~clk;

  assign hready = hro[cur];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] md;
    ahb_imem_slave #(
      .MEM_BYTES(MB),
      .WAIT_CYCLES(WAITS[g]),
      .BASE_ADDR(32'h0000_0000)
    ) u_dut (
      .HCLK(clk),
      .HRESETn(rst_n),
      .HSEL(hsel && (cur == g)),
      .HADDR(haddr),
      .HTRANS(htrans),
      .HWRITE(hwrite),
      .HSIZE(hsize),
      .HBURST(hburst),
      .HREADY(hready),
      .HRDATA(hrdata[g]),
      .HREADYOUT(hro[g]),
      .HRESP(hrs[g]),
      .mem_cen(cen[g]),
      .mem_addr(maddr[g]),
      .mem_dout(md)
    );
    always @(posedge clk) begin
      if (!cen[g]) md <= mem[maddr[g]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input item_t it);
    int unsigned bytes;
    if (it.wr) return 1'b1;
    if (it.size > 3'd2) return 1'b1;
    if (it.addr >= MB) return 1'b1;
    bytes = 1 << it.size;
    return (it.addr % bytes) != 0;
  endfunction

  task automatic add(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] s);
    item_t it;
    it.addr = a; it.trans = t; it.wr = w; it.size = s; it.sel = 1'b1;
    q.push_back(it);
  endtask

  task automatic add_idle();
    add(32'h0, 2'b00, 1'b0, 3'd2);
  endtask

  task automatic add_random(input int n);
    item_t it;
    int r;
    for (int i = 0; i < n; i++) begin
      it.sel  = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      it.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      it.wr   = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      it.size = (r < 6) ? 3'd2 : (r < 7) ? 3'd0 : (r < 9) ? 3'd1 : 3'd3;
      it.addr = $urandom_range(0, 2 * MB - 1);
      if ($urandom_range(0, 3) != 0) it.addr[1:0] = 2'b00;
      q.push_back(it);
    end
    add_idle();
  endtask

  // Drive queued address phases on one instance and check every data-phase cycle.
  task automatic run(input int dut);
    ph_t   dp[$];
    item_t it;
    ph_t   e;
    bit    acc;
    bit    rd;
    int    guard;
    cur = dut;
    guard = 0;
    dp.push_back(ph_t'{1'b1, 1'b0, ldata[dut]});
    while (q.size() > 0 && guard < 4000) begin
      guard++;
      it = q[0];
      e  = dp[0];
      hsel = it.sel; haddr = it.addr; htrans = it.trans; hwrite = it.wr; hsize = it.size;
      hburst = 3'($urandom_range(0, 7));
      acc = it.sel && it.trans[1] && e.rdy;
      rd  = acc && !is_err(it);
      @(negedge clk);
      chk("hreadyout", 32'(hro[dut]), 32'(e.rdy));
      chk("hresp", 32'(hrs[dut]), 32'(e.resp));
      chk("hrdata", hrdata[dut], e.data);
      chk("mem_cen", 32'(cen[dut]), 32'(!rd));
      if (rd) chk("mem_addr", 32'(maddr[dut]), 32'(it.addr[AW+1:2]));
      @(posedge clk);
      #1;
      if (e.rdy) begin
        void'(q.pop_front());
        dp.delete();
        if (!acc) begin
          dp.push_back(ph_t'{1'b1, 1'b0, ldata[dut]});
        end else if (is_err(it)) begin
          dp.push_back(ph_t'{1'b0, 1'b1, ldata[dut]});
          dp.push_back(ph_t'{1'b1, 1'b1, ldata[dut]});
        end else begin
          for (int k = 0; k < WAITS[dut]; k++) dp.push_back(ph_t'{1'b0, 1'b0, ldata[dut]});
          ldata[dut] = mem[it.addr[AW+1:2]];
          dp.push_back(ph_t'{1'b1, 1'b0, ldata[dut]});
        end
      end else begin
        void'(dp.pop_front());
      end
    end
    chk("run_bound", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; cur = 0;
    for (int i = 0; i < MB / 4; i++) mem[i] = $urandom;
    mem[16] = 32'hDEAD_BEEF;
    mem[0]  = 32'h0000_0013;
    mem[2]  = 32'hCAFE_0002;
    for (int g = 0; g < 3; g++) ldata[g] = 32'h0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_hreadyout", 32'(hro[g]), 32'd1);
      chk("rst_hresp", 32'(hrs[g]), 32'd0);
      chk("rst_hrdata", hrdata[g], 32'h0);
      chk("rst_mem_cen", 32'(cen[g]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read, no wait states.
    add(32'h40, 2'b10, 1'b0, 3'd2); add_idle(); run(0);
    // WRAP4 refill starting at 0x18.
    add(32'h18, 2'b10, 1'b0, 3'd2); add(32'h1C, 2'b11, 1'b0, 3'd2);
    add(32'h10, 2'b11, 1'b0, 3'd2); add(32'h14, 2'b11, 1'b0, 3'd2); add_idle(); run(0);
    // Two wait states.
    add(32'h0, 2'b10, 1'b0, 3'd2); add_idle(); run(1);
    // ERROR cases, including a NONSEQ presented in ERR2.
    for (int d = 0; d < 2; d++) begin
      add(32'h4, 2'b10, 1'b1, 3'd2); add_idle();
      add(MB, 2'b10, 1'b0, 3'd2); add_idle();
      add(32'h2, 2'b10, 1'b0, 3'd2); add(32'h40, 2'b10, 1'b0, 3'd2);
      add(32'h8, 2'b10, 1'b0, 3'd3); add(32'h1, 2'b10, 1'b0, 3'd1); add(32'h3, 2'b10, 1'b0, 3'd0);
      add_idle(); run(d);
    end
    // INCR4 with BUSY between beats 2 and 3.
    for (int d = 0; d < 2; d++) begin
      add(32'h20, 2'b10, 1'b0, 3'd2); add(32'h24, 2'b11, 1'b0, 3'd2);
      add(32'h28, 2'b01, 1'b0, 3'd2); add(32'h28, 2'b11, 1'b0, 3'd2);
      add(32'h2C, 2'b11, 1'b0, 3'd2); add_idle(); run(d);
    end
    // Randomized traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      add_random(60); run(d);
    end
    add(32'h44, 2'b10, 1'b0, 3'd2); add_idle(); run(2);

    // Reset during the second wait cycle of a three-wait read.
    cur = 2; hsel = 1'b1; haddr = 32'h0C; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    chk("rd_wait1", 32'(hro[2]), 32'd0);
    @(posedge clk);
    #1;
    chk("rd_wait2", 32'(hro[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_hreadyout", 32'(hro[2]), 32'd1);
    chk("midrst_hresp", 32'(hrs[2]), 32'd0);
    chk("midrst_hrdata", hrdata[2], 32'h0);
    chk("midrst_mem_cen", 32'(cen[2]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) ldata[g] = 32'h0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("postrst_mem_cen", 32'(cen[2]), 32'd1);
      chk("postrst_hreadyout", 32'(hro[2]), 32'd1);
      chk("postrst_hrdata", hrdata[2], 32'h0);
    end
    add(32'h8, 2'b10, 1'b0, 3'd2); add_idle(); run(2);
    add_random(30); run(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
